// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port: one outstanding access, completed when
// mem_ready is high while mem_req is high.
interface mips_multicycle_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq[/j]) on one
// shared memory port. Define MIPS_MC_JUMP_EN to execute opcode 0x02 as j.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic                          clock,
    input  logic                          PCreset,
    mips_multicycle_core_if.master        mem,
    output logic [31:0]                   IMinstruction,
    output logic [31:0]                   Address,
    output logic [31:0]                   RV,
    output logic [31:0]                   SWdata,
    output logic                          halted,
    output logic [2:0]                    state
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, rv_q, rv_d, swdata_q, swdata_d;
    logic        halted_q, halted_d;
    logic [31:0] regs_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [31:0] rs_val, rt_val, wb_val, r_result;
    logic        legal, rf_we;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    // Indices beyond the implemented depth read as zero, like R0.
    assign rs_val = (rs != 5'd0 && int'(rs) < REG_COUNT) ? regs_q[rs] : 32'd0;
    assign rt_val = (rt != 5'd0 && int'(rt) < REG_COUNT) ? regs_q[rt] : 32'd0;

    assign wb_dest = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_val  = (opcode == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_ADDI, OP_BEQ, OP_LW, OP_SW: legal = 1'b1;
`ifdef MIPS_MC_JUMP_EN
            OP_J:     legal = 1'b1;
`endif
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        r_result = 32'd0;
        case (funct)
            FN_ADD:  r_result = a_q + b_q;
            FN_SUB:  r_result = a_q - b_q;
            FN_AND:  r_result = a_q & b_q;
            FN_OR:   r_result = a_q | b_q;
            FN_SLT:  r_result = {31'd0, $signed(a_q) < $signed(b_q)};
            default: r_result = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rv_d     = rv_q;
        swdata_d = swdata_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        case (state_q)
            S_FETCH: if (mem.mem_ready) begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = rs_val;
                b_d      = rt_val;
                imm_d    = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d  = legal ? S_EXEC : S_HALT;
                halted_d = !legal;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin alu_d = r_result;    state_d = S_WB;  end
                    OP_ADDI:  begin alu_d = a_q + imm_q; state_d = S_WB;  end
                    OP_LW, OP_SW: begin alu_d = a_q + imm_q; state_d = S_MEM; end
                    OP_BEQ: begin
                        // pc_q already points past the branch
                        if (a_q == b_q) pc_d = pc_q + {imm_q[29:0], 2'b00};
                        state_d = S_FETCH;
                    end
`ifdef MIPS_MC_JUMP_EN
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
`endif
                    default: begin state_d = S_HALT; halted_d = 1'b1; end
                endcase
            end
            S_MEM: if (mem.mem_ready) begin
                if (opcode == OP_SW) begin
                    swdata_d = b_q;
                    state_d  = S_FETCH;
                end else begin
                    mdr_d    = mem.mem_rdata;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (wb_dest != 5'd0) begin
                    rv_d  = wb_val;
                    rf_we = int'(wb_dest) < REG_COUNT;
                end
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge PCreset) begin
        if (PCreset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            imm_q    <= 32'd0;
            alu_q    <= 32'd0;
            mdr_q    <= 32'd0;
            rv_q     <= 32'd0;
            swdata_q <= 32'd0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            rv_q     <= rv_d;
            swdata_q <= swdata_d;
            halted_q <= halted_d;
            if (rf_we) regs_q[wb_dest] <= wb_val;
        end
    end

    // Request is masked during reset so an aborted access drops at once.
    assign mem.mem_req   = !PCreset && (state_q == S_FETCH || state_q == S_MEM);
    assign mem.mem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    assign mem.mem_addr  = (state_q == S_MEM) ? {alu_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
    assign mem.mem_wdata = b_q;

    assign IMinstruction = ir_q;
    assign Address       = pc_q;
    assign RV            = rv_q;
    assign SWdata        = swdata_q;
    assign halted        = halted_q;
    assign state         = state_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed programs for mips_multicycle_core; a monitor checks every memory
// transaction against an expected-transaction queue and request stability.
module tb_mips_multicycle_core;
    logic        clock = 1'b0;
    logic        PCreset = 1'b1;
    logic [31:0] IMinstruction, Address, RV, SWdata;
    logic        halted;
    logic [2:0]  state;

    mips_multicycle_core_if mif();

    mips_multicycle_core dut (
        .clock(clock), .PCreset(PCreset), .mem(mif),
        .IMinstruction(IMinstruction), .Address(Address), .RV(RV),
        .SWdata(SWdata), .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
    txn_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory responder: mem_ready after wait_n stall cycles.
    logic [31:0] mem [256];
    int          wait_n = 0;
    int          wcnt;
    assign mif.mem_ready = mif.mem_req && (wcnt >= wait_n);
    assign mif.mem_rdata = mem[mif.mem_addr[9:2]];

    always @(posedge clock or posedge PCreset) begin
        if (PCreset) wcnt <= 0;
        else if (mif.mem_req) wcnt <= mif.mem_ready ? 0 : wcnt + 1;
    end

    logic        pend;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;

    always @(negedge clock) begin
        if (PCreset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                n_tests++;
                if (mif.mem_req !== 1'b1 || mif.mem_we !== p_we ||
                    mif.mem_addr !== p_addr || mif.mem_wdata !== p_wdata) begin
                    n_fail++;
                    $display("FAIL hold: req=%b we=%b addr=%h wdata=%h, required req=1 we=%b addr=%h wdata=%h",
                             mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, p_we, p_addr, p_wdata);
                end
            end
            if (mif.mem_req && mif.mem_ready && exp_q.size() != 0) begin
                n_tests++;
                if (mif.mem_we !== exp_q[0].we || mif.mem_addr !== exp_q[0].addr ||
                    (exp_q[0].we && mif.mem_wdata !== exp_q[0].data)) begin
                    n_fail++;
                    $display("FAIL txn: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             mif.mem_we, mif.mem_addr, mif.mem_wdata,
                             exp_q[0].we, exp_q[0].addr, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end
            pend    <= mif.mem_req && !mif.mem_ready;
            p_we    <= mif.mem_we;
            p_addr  <= mif.mem_addr;
            p_wdata <= mif.mem_wdata;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w); mem[a[9:2]] = w; endtask
    task automatic exp_f(input logic [31:0] a); exp_q.push_back('{1'b0, a, 32'd0}); endtask
    task automatic exp_l(input logic [31:0] a); exp_q.push_back('{1'b0, a, 32'd0}); endtask
    task automatic exp_s(input logic [31:0] a, input logic [31:0] d); exp_q.push_back('{1'b1, a, d}); endtask
    task automatic ins(input logic [31:0] a, input logic [31:0] w); put(a, w); exp_f(a); endtask

    task automatic start(input int w);
        @(posedge clock); #2;
        PCreset = 1'b1;
        exp_q.delete();
        wait_n = w;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask
    task automatic go();
        @(posedge clock); #2;
        PCreset = 1'b0;
    endtask
    task automatic cyc(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask
    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin cyc(1); n++; end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    localparam int ADD = 32'h20, SUB = 32'h22, AND = 32'h24, OR = 32'h25, SLT = 32'h2A;

    initial begin
        int req_seen;
        // addi/addi/add with zero-wait memory, plus reset state
        start(0);
        ins(32'h00, enc_i(8, 0, 1, 5));
        ins(32'h04, enc_i(8, 0, 2, 7));
        ins(32'h08, enc_r(1, 2, 3, ADD));
        #1;
        chk("rst_pc", Address, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir", IMinstruction, 32'h0);
        chk("rst_rv", RV, 32'h0);
        chk("rst_sw", SWdata, 32'h0);
        chk("rst_halt", 32'(halted), 32'd0);
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        go(); #1;
        chk("req_after_rst", 32'(mif.mem_req), 32'd1);
        cyc(11); chk("rv_c11", RV, 32'd7);
        cyc(1);  chk("rv_c12", RV, 32'd12);
        chk("pc_c12", Address, 32'h0C);
        drain(20);

        // sw/lw with two wait states per access
        start(2);
        put(32'h10, 32'd12);
        ins(32'h00, enc_i(8, 0, 3, 12));
        ins(32'h04, enc_i(32'h2B, 0, 3, 32'h10)); exp_s(32'h10, 32'd12);
        ins(32'h08, enc_i(32'h23, 0, 4, 32'h10)); exp_l(32'h10);
        ins(32'h0C, enc_i(32'h2B, 0, 4, 32'h14)); exp_s(32'h14, 32'd12);
        go();
        drain(200);
        cyc(6);
        chk("ws_swdata", SWdata, 32'd12);
        chk("ws_rv_lw", RV, 32'd12);
        chk("ws_halt", 32'(halted), 32'd1);

        // reset while a store is stalled in MEM
        start(3);
        ins(32'h00, enc_i(8, 0, 3, 12));
        ins(32'h04, enc_i(32'h2B, 0, 3, 32'h10));
        go();
        begin
            int n = 0;
            while (state != 3'd3 && n < 100) begin cyc(1); n++; end
        end
        chk("abort_in_mem", 32'(state), 32'd3);
        cyc(1);
        PCreset = 1'b1; #1;
        chk("abort_req_drop", 32'(mif.mem_req), 32'd0);
        cyc(1);
        PCreset = 1'b0; #1;
        chk("abort_swdata", SWdata, 32'd0);
        chk("abort_rv", RV, 32'd0);
        chk("abort_pc", Address, 32'h0);

        // taken beq loop at 0x20
        start(0);
        ins(32'h00, enc_i(8, 0, 1, 3));
        ins(32'h04, enc_i(4, 0, 0, 6));
        ins(32'h20, enc_i(4, 1, 1, -1)); exp_f(32'h20); exp_f(32'h20);
        go();
        cyc(7); chk("beq_c7", Address, 32'h20);
        cyc(1); chk("beq_c8", Address, 32'h24);
        cyc(2); chk("beq_c10", Address, 32'h20);
        cyc(3); chk("beq_c13", Address, 32'h20);
        drain(20);

        // untaken beq falls through
        start(0);
        ins(32'h00, enc_i(8, 0, 1, 3));
        ins(32'h04, enc_i(4, 0, 0, 6));
        ins(32'h20, enc_i(4, 1, 0, -1));
        ins(32'h24, 32'h0);
        go();
        cyc(10); chk("bne_c10", Address, 32'h24);
        drain(20);

        // R0 writes, ALU ops, signed slt, negative/unaligned offsets
        start(0);
        put(32'h98, 32'hFFFF_FFFE);
        ins(32'h00, enc_i(8, 0, 1, 5));
        ins(32'h04, enc_i(8, 0, 0, 9));
        ins(32'h08, enc_r(0, 0, 5, ADD));
        ins(32'h0C, enc_i(32'h2B, 0, 5, 32'h80)); exp_s(32'h80, 32'd0);
        ins(32'h10, enc_i(8, 0, 7, -1));
        ins(32'h14, enc_i(8, 0, 8, 1));
        ins(32'h18, enc_r(7, 8, 6, SLT));
        ins(32'h1C, enc_i(32'h2B, 0, 6, 32'h84)); exp_s(32'h84, 32'd1);
        ins(32'h20, enc_r(8, 7, 9, SUB));
        ins(32'h24, enc_i(32'h2B, 0, 9, 32'h88)); exp_s(32'h88, 32'd2);
        ins(32'h28, enc_r(7, 1, 10, AND));
        ins(32'h2C, enc_r(1, 9, 11, OR));
        ins(32'h30, enc_i(32'h2B, 0, 10, 32'h8C)); exp_s(32'h8C, 32'd5);
        ins(32'h34, enc_i(32'h2B, 0, 11, 32'h90)); exp_s(32'h90, 32'd7);
        ins(32'h38, enc_r(8, 7, 12, SLT));
        ins(32'h3C, enc_r(7, 7, 13, ADD));
        ins(32'h40, enc_i(32'h2B, 0, 12, 32'h94)); exp_s(32'h94, 32'd0);
        ins(32'h44, enc_i(32'h2B, 0, 13, 32'h98)); exp_s(32'h98, 32'hFFFF_FFFE);
        ins(32'h48, enc_i(8, 0, 15, 32'hA0));
        ins(32'h4C, enc_i(32'h23, 15, 14, -6)); exp_l(32'h98);
        ins(32'h50, enc_i(32'h2B, 15, 14, 4)); exp_s(32'hA4, 32'hFFFF_FFFE);
        ins(32'h54, 32'h0);
        go();
        cyc(8); chk("r0_rv_kept", RV, 32'd5);
        cyc(4); chk("add_r0_rv", RV, 32'd0);
        drain(200);
        cyc(3);
        chk("alu_halt", 32'(halted), 32'd1);
        chk("alu_rv_lw", RV, 32'hFFFF_FFFE);
        chk("alu_swdata", SWdata, 32'hFFFF_FFFE);

        // illegal opcode halts; reset recovers
        start(0);
        ins(32'h00, {6'h3F, 26'd0});
        go();
        cyc(1);
        chk("ill_decode_halt", 32'(halted), 32'd0);
        chk("ill_decode_state", 32'(state), 32'd1);
        cyc(1);
        chk("ill_halt", 32'(halted), 32'd1);
        chk("ill_state", 32'(state), 32'd5);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mif.mem_req !== 1'b0 || Address !== 32'h4) req_seen++;
            cyc(1);
        end
        chk("ill_frozen_cycles", 32'(req_seen), 32'd0);
        PCreset = 1'b1; #1;
        chk("ill_rst_pc", Address, 32'h0);
        chk("ill_rst_halt", 32'(halted), 32'd0);
        chk("ill_rst_state", 32'(state), 32'd0);

        // j 0x40 from PC 0
        start(0);
        ins(32'h00, {6'h02, 26'h40});
`ifdef MIPS_MC_JUMP_EN
        exp_f(32'h100);
`endif
        go();
        cyc(3);
`ifdef MIPS_MC_JUMP_EN
        chk("j_target", Address, 32'h100);
        chk("j_not_halted", 32'(halted), 32'd0);
`else
        chk("j_illegal_halt", 32'(halted), 32'd1);
        chk("j_illegal_pc", Address, 32'h4);
`endif
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multicycle successor to the single-cycle MIPS top level: one shared ALU, a register file and a control FSM, executing one instruction over 3–5 states. Instruction and data share an external single-port memory reached through a req/ready handshake, so memories with wait states are supported. Register-file depth and reset vector are parameters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- REG_COUNT, 32, implemented registers (16 or 32); index ≥ REG_COUNT reads 0, writes dropped
- clock  in  1  single clock, rising edge
- PCreset  in  1  reset, asynchronous, active-high
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = load/fetch
- mem_addr  out  32  byte address, bits[1:0] forced 0
- mem_wdata  out  32  store data
- mem_rdata  in  32  load/fetch data, valid when mem_ready=1
- mem_ready  in  1  access completes on this edge when mem_req=1
- IMinstruction  out  32  instruction register
- Address  out  32  current PC
- RV  out  32  last register writeback value
- SWdata  out  32  last stored data
- halted  out  1  core stopped on illegal instruction
- state  out  3  FSM state code (debug)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR←mem_rdata, PC←PC+4, →DECODE. Otherwise stay.
- DECODE: A←R[rs], B←R[rt], imm←sign-extended [15:0]; illegal opcode/funct →HALT, else →EXEC.
- EXEC by opcode:
  - 0x00 R-type: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); →WB, dest rd.
  - 0x08 addi: A+imm; →WB, dest rt.
  - 0x23 lw / 0x2B sw: addr←A+imm; →MEM.
  - 0x04 beq: if A==B, PC←PC+(imm<<2); →FETCH.
  - 0x02 j (macro-dependent): PC←{PC[31:28],IR[25:0],2'b00}; →FETCH.
- MEM: mem_req=1, mem_addr=addr&~3; sw: mem_we=1, mem_wdata=B; on ready SWdata←B, →FETCH. lw: on ready MDR←mem_rdata, →WB.
- WB: R[dest]←result (MDR for lw), RV←same value, unless dest=0; →FETCH.
- HALT: mem_req=0, halted=1, PC/registers frozen until reset.
- Arithmetic 32-bit, wraps, no overflow exception. R0 always reads 0.
- mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ready sampled high; mem_ready ignored when mem_req=0.

## Timing
- Reset (async assert): PC=RESET_PC, state=FETCH, IR=0, RV=0, SWdata=0, halted=0, all registers 0. mem_req=1 (combinational from FETCH) from first cycle after reset.
- Zero-wait memory (mem_ready=1 same cycle): beq/j 3 cycles, R-type/addi/sw 4, lw 5. Each wait cycle adds one.
- Register write in WB visible to DECODE of next instruction (no bypass needed).
- Reset mid-access: request drops immediately; no register or SWdata update from the aborted access.
- Branch/jump target takes effect in the next FETCH; no delay slot.

## Configuration
- MIPS_MC_JUMP_EN defined: opcode 0x02 executes as j.
- Undefined: opcode 0x02 illegal → HALT after DECODE, halted=1.

## Test plan
- Reset, zero-wait memory, program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 → R3=12, RV=12 at 12th cycle after reset release.
- sw $3,0x10($0) then lw $4,0x10($0) with mem_ready delayed 2 cycles each → mem write addr 0x10 data 12, SWdata=12, R4=12; request signals stable during waits.
- beq $1,$1,-1 at PC=0x20 → PC returns to 0x20 each 3 cycles; beq with unequal operands → PC=0x24.
- addi $0,$0,9 then add $5,$0,$0 → R5=0; slt $6,$7,$8 with R7=-1, R8=1 → R6=1.
- Opcode 0x3F → halted=1 in cycle after DECODE, mem_req=0 forever; PCreset pulse → PC=RESET_PC, halted=0.
- j 0x40 at PC=0: with MIPS_MC_JUMP_EN next fetch address 0x100; without it halted=1.
